// File: rtl/cnn_conv2_pkg.sv
// Shared definitions for the conv2 accumulate / requantise stage.
// Holds the default widths and tap count used by the top, the interface and
// the requantiser, the FSM state encoding, and a small counter-width helper.
package cnn_conv2_pkg;

  localparam int DEF_PROD_W     = 20;
  localparam int DEF_ACC_W      = 32;
  localparam int DEF_N_TAPS     = 150;
  localparam int DEF_BIAS_W     = 14;
  localparam int DEF_FRAC_SHIFT = 5;
  localparam int DEF_OUT_W      = 14;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_FINAL  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

  // Tap counter width; a single-tap pixel still needs one bit.
  function automatic int cnt_width(input int n_taps);
    return (n_taps > 1) ? $clog2(n_taps) : 1;
  endfunction

endpackage

// File: rtl/cnn_conv2_acc_relu_if.sv
// Bundles the product input stream, the per-pixel bias, the activation output
// stream and the sticky framing error flag of the conv2 accumulate stage.
//   master : the side that produces products/bias and consumes activations
//   slave  : the accumulate stage itself
//   prod_tdata/prod_tvalid/prod_tready/prod_tlast : product stream
//   bias                                          : signed bias, output scale
//   out_tdata/out_tvalid/out_tready               : activation stream
//   err_tlast                                     : sticky tlast mismatch
interface cnn_conv2_acc_relu_if #(
  parameter int PROD_W = cnn_conv2_pkg::DEF_PROD_W,
  parameter int BIAS_W = cnn_conv2_pkg::DEF_BIAS_W,
  parameter int OUT_W  = cnn_conv2_pkg::DEF_OUT_W
);

  logic signed [PROD_W-1:0] prod_tdata;
  logic                     prod_tvalid;
  logic                     prod_tready;
  logic                     prod_tlast;
  logic signed [BIAS_W-1:0] bias;
  logic        [OUT_W-1:0]  out_tdata;
  logic                     out_tvalid;
  logic                     out_tready;
  logic                     err_tlast;

  modport master (
    output prod_tdata, prod_tvalid, prod_tlast, bias, out_tready,
    input  prod_tready, out_tdata, out_tvalid, err_tlast
  );

  modport slave (
    input  prod_tdata, prod_tvalid, prod_tlast, bias, out_tready,
    output prod_tready, out_tdata, out_tvalid, err_tlast
  );

endinterface

// File: rtl/cnn_conv2_requant.sv
// Combinational requantiser: turns a finished accumulator value (product
// scale) into an OUT_W-bit activation.
//   acc_i : signed accumulator, ACC_W bits
//   act_o : activation, round-half-up, ReLU, positive saturation (MSB is 0)
module cnn_conv2_requant #(
  parameter int ACC_W      = cnn_conv2_pkg::DEF_ACC_W,
  parameter int FRAC_SHIFT = cnn_conv2_pkg::DEF_FRAC_SHIFT,
  parameter int OUT_W      = cnn_conv2_pkg::DEF_OUT_W
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [OUT_W-1:0] act_o
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (FRAC_SHIFT-1);
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((1 << (OUT_W-1)) - 1);

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] r;

  // Adding half an LSB then shifting arithmetically rounds ties toward +inf.
  // ReLU is applied first, so saturation is only needed on the positive side.
  always_comb begin
    sum = $signed({acc_i[ACC_W-1], acc_i}) + HALF;
    r   = sum >>> FRAC_SHIFT;
    if (r[ACC_W]) begin
      act_o = '0;
    end else if (r > MAXV) begin
      act_o = MAXV[OUT_W-1:0];
    end else begin
      act_o = r[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/cnn_conv2_acc_relu.sv
// conv2 output-pixel stage: accumulates N_TAPS signed products, adds the bias
// (sampled on the first tap of each pixel), requantises and emits one
// activation per pixel.
//   ap_clk   : clock, rising edge
//   ap_rst_n : asynchronous active-low reset; a partial pixel is discarded
//   bus      : slave side of cnn_conv2_acc_relu_if (product stream in, bias,
//              activation stream out, sticky tlast framing error)
module cnn_conv2_acc_relu
  import cnn_conv2_pkg::*;
#(
  parameter int PROD_W     = DEF_PROD_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int N_TAPS     = DEF_N_TAPS,
  parameter int BIAS_W     = DEF_BIAS_W,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int OUT_W      = DEF_OUT_W
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  cnn_conv2_acc_relu_if.slave  bus
);

  localparam int              CNT_W    = cnt_width(N_TAPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TAPS - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]         out_tdata_q, out_tdata_d;
  logic                     out_tvalid_q, out_tvalid_d;
  logic                     err_q, err_d;

  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic [OUT_W-1:0]         act;
  logic                     tap_ok;
  logic                     last_tap;

  cnn_conv2_requant #(
    .ACC_W      (ACC_W),
    .FRAC_SHIFT (FRAC_SHIFT),
    .OUT_W      (OUT_W)
  ) u_requant (
    .acc_i (acc_q),
    .act_o (act)
  );

  // Gating with the reset keeps prod_tready low while reset is held, even
  // though the state register already sits in ACCUM.
  assign bus.prod_tready = (state_q == ST_ACCUM) && ap_rst_n;
  assign bus.out_tdata   = out_tdata_q;
  assign bus.out_tvalid  = out_tvalid_q;
  assign bus.err_tlast   = err_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= ST_ACCUM;
      cnt_q        <= '0;
      acc_q        <= '0;
      out_tdata_q  <= '0;
      out_tvalid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      out_tdata_q  <= out_tdata_d;
      out_tvalid_q <= out_tvalid_d;
      err_q        <= err_d;
    end
  end

  // Pixel framing is driven purely by the tap counter; prod_tlast only feeds
  // the sticky error flag. The first tap seeds the accumulator with the bias
  // pre-scaled to product scale, so no separate clear cycle is needed.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    out_tdata_d  = out_tdata_q;
    out_tvalid_d = out_tvalid_q;
    err_d        = err_q;

    prod_ext = {{(ACC_W-PROD_W){bus.prod_tdata[PROD_W-1]}}, bus.prod_tdata};
    bias_ext = $signed({{(ACC_W-BIAS_W){bus.bias[BIAS_W-1]}}, bus.bias}) <<< FRAC_SHIFT;
    tap_ok   = bus.prod_tvalid && bus.prod_tready;
    last_tap = (cnt_q == CNT_LAST);

    case (state_q)
      ST_ACCUM: begin
        if (tap_ok) begin
          if (cnt_q == '0) begin
            acc_d = bias_ext + prod_ext;
          end else begin
            acc_d = acc_q + prod_ext;
          end
          if (bus.prod_tlast != last_tap) begin
            err_d = 1'b1;
          end
          if (last_tap) begin
            cnt_d   = '0;
            state_d = ST_FINAL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_FINAL: begin
        out_tdata_d  = act;
        out_tvalid_d = 1'b1;
        state_d      = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_tvalid_q && bus.out_tready) begin
          out_tvalid_d = 1'b0;
          state_d      = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

endmodule

// File: tb/tb_cnn_conv2_acc_relu.sv
// Bench for cnn_conv2_acc_relu. Two instances share clock and reset: one with
// the default 150-tap configuration for directed pixels, one with 4 taps for
// random traffic. A per-pixel reference model (sum of taps, bias, rounding,
// clamp) predicts every output cycle of both instances.
module tb_cnn_conv2_acc_relu;

  localparam int  FRAC  = 5;
  localparam longint OMAX = 8191;

  logic apClk = 1'b0;
  logic apRstN = 1'b0;
  longint cyc = 0;

  int total = 0;
  int bad = 0;
  int rndPixels = 0;

  cnn_conv2_acc_relu_if #(.PROD_W(20), .BIAS_W(14), .OUT_W(14)) dirIf ();
  cnn_conv2_acc_relu_if #(.PROD_W(20), .BIAS_W(14), .OUT_W(14)) rndIf ();

  cnn_conv2_acc_relu #(.N_TAPS(150)) dutDir (
    .ap_clk   (apClk),
    .ap_rst_n (apRstN),
    .bus      (dirIf.slave)
  );

  cnn_conv2_acc_relu #(.N_TAPS(4)) dutRnd (
    .ap_clk   (apClk),
    .ap_rst_n (apRstN),
    .bus      (rndIf.slave)
  );

  always #5 apClk = ~apClk;

  always @(posedge apClk) cyc <= cyc + 1;

  // Model state, one slot per instance (0 = directed, 1 = random).
  int     tapCnt[2];
  longint accSum[2];
  longint biasLatch[2];
  bit     pendValid[2];
  longint pendVal[2];
  longint pendDue[2];
  bit     errExp[2];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Pixel result from first principles: bias at output scale plus the tap
  // sum, round half up, ReLU, clamp to the positive output range.
  function automatic longint refResult(input longint b, input longint s);
    longint v;
    v = (b * (64'sd1 <<< FRAC) + s + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
    if (v < 0) v = 0;
    if (v > OMAX) v = OMAX;
    return v;
  endfunction

  // Behaviour seen from outside: the stage takes taps only while it holds no
  // finished pixel; a pixel's result appears two cycles after its last tap is
  // taken and is held until transferred.
  task automatic modelStep(input int d, input int nTaps, input logic rstn,
                           input logic tv, input logic tr, input logic tl,
                           input longint td, input longint bv,
                           input logic ov, input logic ordy, input longint od,
                           input logic er);
    bit expValid;
    bit canTake;
    string p;
    p = (d == 0) ? "dir" : "rnd";
    if (!rstn) begin
      checkOutput({p, "_rst_ready"}, tr, 0);
      checkOutput({p, "_rst_valid"}, ov, 0);
      checkOutput({p, "_rst_err"}, er, 0);
      tapCnt[d] = 0; accSum[d] = 0; pendValid[d] = 0; errExp[d] = 0;
      return;
    end
    canTake  = !pendValid[d];
    expValid = pendValid[d] && (cyc >= pendDue[d]);
    checkOutput({p, "_ready"}, tr, canTake);
    checkOutput({p, "_valid"}, ov, expValid);
    if (expValid) checkOutput({p, "_data"}, od, pendVal[d]);
    checkOutput({p, "_err"}, er, errExp[d]);
    if (expValid && ordy) begin
      pendValid[d] = 0;
      if (d == 1) rndPixels++;
    end
    if (tv && canTake) begin
      if (tapCnt[d] == 0) begin
        biasLatch[d] = bv;
        accSum[d] = 0;
      end
      accSum[d] += td;
      if (tl != (tapCnt[d] == nTaps - 1)) errExp[d] = 1;
      tapCnt[d]++;
      if (tapCnt[d] == nTaps) begin
        pendValid[d] = 1;
        pendVal[d]   = refResult(biasLatch[d], accSum[d]);
        pendDue[d]   = cyc + 2;
        tapCnt[d]    = 0;
      end
    end
  endtask

  always @(negedge apClk) begin
    modelStep(0, 150, apRstN, dirIf.prod_tvalid, dirIf.prod_tready, dirIf.prod_tlast,
              longint'(dirIf.prod_tdata), longint'(dirIf.bias),
              dirIf.out_tvalid, dirIf.out_tready, longint'(dirIf.out_tdata), dirIf.err_tlast);
    modelStep(1, 4, apRstN, rndIf.prod_tvalid, rndIf.prod_tready, rndIf.prod_tlast,
              longint'(rndIf.prod_tdata), longint'(rndIf.bias),
              rndIf.out_tvalid, rndIf.out_tready, longint'(rndIf.out_tdata), rndIf.err_tlast);
  end

  // Sends nTaps products of value data to the directed instance, raising
  // tlast on tap number tlastTap (0 = never). Returns just after the edge
  // that took the last tap.
  task automatic applyStimulus(input int biasv, input int data, input int tlastTap, input int nTaps);
    int w;
    for (int i = 1; i <= nTaps; i++) begin
      dirIf.prod_tdata  = 20'(data);
      dirIf.bias        = 14'(biasv);
      dirIf.prod_tlast  = (i == tlastTap);
      dirIf.prod_tvalid = 1'b1;
      w = 0;
      do begin
        @(negedge apClk);
        w++;
      end while (!dirIf.prod_tready && w < 100);
      if (w >= 100) checkOutput("tap_wait_timeout", w, 0);
      @(posedge apClk);
      #1;
    end
    dirIf.prod_tvalid = 1'b0;
    dirIf.prod_tlast  = 1'b0;
  endtask

  // Waits for the activation after the last tap and checks latency/value.
  task automatic waitOutput(input string name, input longint expData);
    int n;
    n = 0;
    do begin
      @(negedge apClk);
      n++;
    end while (!dirIf.out_tvalid && n < 50);
    checkOutput({name, "_latency"}, n, 2);
    checkOutput({name, "_data"}, dirIf.out_tdata, expData);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    dirIf.prod_tdata = '0; dirIf.prod_tvalid = 1'b0; dirIf.prod_tlast = 1'b0;
    dirIf.bias = '0; dirIf.out_tready = 1'b1;
    rndIf.prod_tdata = '0; rndIf.prod_tvalid = 1'b0; rndIf.prod_tlast = 1'b0;
    rndIf.bias = '0; rndIf.out_tready = 1'b1;

    // Reset state
    repeat (3) @(posedge apClk);
    #1;
    checkOutput("reset_ready", dirIf.prod_tready, 0);
    checkOutput("reset_valid", dirIf.out_tvalid, 0);
    checkOutput("reset_tdata", dirIf.out_tdata, 0);
    checkOutput("reset_err", dirIf.err_tlast, 0);
    @(negedge apClk);
    #2 apRstN = 1'b1;
    #1 checkOutput("post_reset_ready", dirIf.prod_tready, 1);
    @(posedge apClk);
    #1;

    // Hand-computed anchors for the reference model
    checkOutput("pin_case1", refResult(5, 150 * 32), 155);
    checkOutput("pin_relu", refResult(0, -15000), 0);
    checkOutput("pin_sat", refResult(8191, 150 * 524287), 8191);
    checkOutput("pin_half_up", refResult(0, 48), 2);
    checkOutput("pin_below_half", refResult(0, 47), 1);
    checkOutput("pin_neg_small", refResult(0, -17), 0);

    // 1: nominal pixel
    applyStimulus(5, 32, 150, 150);
    waitOutput("t1", 155);
    checkOutput("t1_err", dirIf.err_tlast, 0);
    @(posedge apClk); #1;

    // 2: negative sum clipped by ReLU
    applyStimulus(0, -100, 150, 150);
    waitOutput("t2", 0);
    @(posedge apClk); #1;

    // 3: positive saturation, no accumulator wrap
    applyStimulus(8191, 524287, 150, 150);
    waitOutput("t3", 8191);
    @(posedge apClk); #1;

    // 4: consumer back-pressure
    dirIf.out_tready = 1'b0;
    applyStimulus(5, 32, 150, 150);
    waitOutput("t4", 155);
    for (int i = 0; i < 10; i++) begin
      @(negedge apClk);
      checkOutput("t4_hold_valid", dirIf.out_tvalid, 1);
      checkOutput("t4_hold_data", dirIf.out_tdata, 155);
      checkOutput("t4_hold_ready", dirIf.prod_tready, 0);
    end
    @(posedge apClk); #1;
    dirIf.out_tready = 1'b1;
    @(negedge apClk);
    checkOutput("t4_xfer_valid", dirIf.out_tvalid, 1);
    @(negedge apClk);
    checkOutput("t4_after_valid", dirIf.out_tvalid, 0);
    checkOutput("t4_after_ready", dirIf.prod_tready, 1);
    @(posedge apClk); #1;

    // 5: early tlast sets the sticky error, framing unaffected
    applyStimulus(5, 32, 10, 150);
    waitOutput("t5", 155);
    checkOutput("t5_err", dirIf.err_tlast, 1);
    @(posedge apClk); #1;
    applyStimulus(0, 64, 150, 150);
    waitOutput("t5b", 300);
    checkOutput("t5_err_sticky", dirIf.err_tlast, 1);
    @(posedge apClk); #1;

    // 6: asynchronous reset in the middle of a pixel
    applyStimulus(5, 32, 0, 70);
    #2 apRstN = 1'b0;
    #1;
    checkOutput("t6_rst_ready", dirIf.prod_tready, 0);
    checkOutput("t6_rst_valid", dirIf.out_tvalid, 0);
    checkOutput("t6_rst_tdata", dirIf.out_tdata, 0);
    checkOutput("t6_rst_err", dirIf.err_tlast, 0);
    repeat (2) @(negedge apClk);
    #2 apRstN = 1'b1;
    @(posedge apClk); #1;
    applyStimulus(-3, 7, 150, 150);
    waitOutput("t6", 30);
    checkOutput("t6_err", dirIf.err_tlast, 0);
    @(posedge apClk); #1;

    // Random traffic on the 4-tap instance
    for (int i = 0; i < 600; i++) begin
      rndIf.prod_tvalid = ($urandom_range(0, 3) != 0);
      rndIf.prod_tdata  = 20'($urandom);
      rndIf.bias        = 14'($urandom);
      rndIf.prod_tlast  = ($urandom_range(0, 15) == 0);
      rndIf.out_tready  = ($urandom_range(0, 2) != 0);
      @(posedge apClk); #1;
    end
    rndIf.prod_tvalid = 1'b0;
    rndIf.out_tready  = 1'b1;
    repeat (10) @(posedge apClk);
    #1;
    checkOutput("rnd_pixels_seen", (rndPixels >= 20) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
